// File: rtl/barrel_shifter32_if.sv
// barrel_shifter32_if: operand/result bundle for the 32-bit shift unit.
// The master drives operands; the slave (the shifter) returns the result.
interface barrel_shifter32_if;
    logic        in_valid;
    logic [31:0] a;
    logic [5:0]  b;
    logic [2:0]  aluc;
    logic        out_valid;
    logic [31:0] c;

    modport master (output in_valid, a, b, aluc, input out_valid, c);
    modport slave  (input in_valid, a, b, aluc, output out_valid, c);
endinterface

// File: rtl/barrel_shifter32.sv
// barrel_shifter32: registered 32-bit SRA/SRL/SLL shifter, 5-stage log mux
// network, one cycle latency, one result per cycle.
// Optional macro BARRELSHIFTER32_OVERSHIFT_EN: b[5] forces an amount >= 32.
module barrel_shifter32 (
    input  logic               clk,
    input  logic               rst_n,
    barrel_shifter32_if.slave  bus
);
    localparam int STAGES = 5;

    logic              is_left;
    logic              fill;
    logic [31:0]       src;
    logic [31:0]       net_out;
    logic [31:0]       shift_res;
    logic [STAGES:0][31:0] stage;

    // Left shifts reuse the right-shift network on a bit-reversed operand.
    assign is_left = bus.aluc[1];
    assign fill    = (bus.aluc[1:0] == 2'b00) ? bus.a[31] : 1'b0;

    // Bit-reverse the operand on the way in for left shifts.
    always_comb begin
        src = bus.a;
        if (is_left) begin
            for (int i = 0; i < 32; i++) src[i] = bus.a[31-i];
        end
    end

    assign stage[0] = src;

    // Stage i shifts right by 2**i when b[i] is set, injecting the fill bit.
    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            localparam int SH = 1 << i;
            assign stage[i+1] = bus.b[i] ? {{SH{fill}}, stage[i][31:SH]} : stage[i];
        end
    endgenerate

    // Undo the input reversal for left shifts.
    always_comb begin
        net_out = stage[STAGES];
        if (is_left) begin
            for (int i = 0; i < 32; i++) net_out[i] = stage[STAGES][31-i];
        end
    end

`ifdef BARRELSHIFTER32_OVERSHIFT_EN
    // Overshift saturates: everything shifted out, only SRA sign fill remains.
    logic unused_aluc2;
    assign unused_aluc2 = bus.aluc[2];
    assign shift_res = bus.b[5] ? {32{fill}} : net_out;
`else
    // Distance is modulo 32; b[5] and aluc[2] play no part.
    logic unused_bits;
    assign unused_bits = ^{bus.b[5], bus.aluc[2]};
    assign shift_res = net_out;
`endif

    // Result register: capture on in_valid, hold otherwise; valid tracks in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.c         <= 32'h0000_0000;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) bus.c <= shift_res;
        end
    end
endmodule

// File: tb/tb_barrel_shifter32.sv
// tb_barrel_shifter32: directed checks of barrel_shifter32 with a behavioural
// reference built from SV shift operators.
module tb_barrel_shifter32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    barrel_shifter32_if bus ();

    barrel_shifter32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [5:0] b,
                                              input logic [2:0] aluc);
        int unsigned sh;
        sh = b[4:0];
`ifdef BARRELSHIFTER32_OVERSHIFT_EN
        if (b[5]) begin
            if (aluc[1:0] == 2'b00) return a[31] ? 32'hFFFF_FFFF : 32'h0;
            return 32'h0;
        end
`endif
        case (aluc[1:0])
            2'b00:   return $unsigned($signed(a) >>> sh);
            2'b01:   return a >> sh;
            default: return a << sh;
        endcase
    endfunction

    // Present operands, take one edge, sample 1 time unit after it.
    task automatic step(input logic v, input logic [31:0] a, input logic [5:0] b,
                        input logic [2:0] aluc);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.aluc     = aluc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ops [2];
        logic [31:0] held;
        ops[0] = 32'hF0C3961E;
        ops[1] = 32'h7A5B3C2D;

        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.aluc = '0;

        // Reset state
        #12;
        check("reset_c", bus.c, 32'h0);
        check("reset_vld", {31'b0, bus.out_valid}, 32'h0);

        // Get a nonzero result, then reset mid-cycle
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h1234_5678, 6'd0, 3'b001);
        check("pre_rst_c", bus.c, 32'h1234_5678);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_c", bus.c, 32'h0);
        check("async_rst_vld", {31'b0, bus.out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after release
        step(1'b1, 32'hF0C3961E, 6'd0, 3'b000);
        check("post_rst_c", bus.c, 32'hF0C3961E);
        check("post_rst_vld", {31'b0, bus.out_valid}, 32'h1);

        // Hand-computed vectors
        step(1'b1, 32'hF0C3961E, 6'd4, 3'b000);  check("sra4", bus.c, 32'hFF0C3961);
        step(1'b1, 32'hF0C3961E, 6'd4, 3'b001);  check("srl4", bus.c, 32'h0F0C3961);
        step(1'b1, 32'hF0C3961E, 6'd4, 3'b010);  check("sll4", bus.c, 32'h0C3961E0);
        step(1'b1, 32'hF0C3961E, 6'd4, 3'b011);  check("sla4", bus.c, 32'h0C3961E0);
        step(1'b1, 32'hF0C3961E, 6'd1, 3'b010);  check("sll1", bus.c, 32'hE1872C3C);
        step(1'b1, 32'hF0C3961E, 6'd31, 3'b000); check("sra31", bus.c, 32'hFFFFFFFF);
        step(1'b1, 32'hF0C3961E, 6'd31, 3'b001); check("srl31", bus.c, 32'h00000001);
        step(1'b1, 32'hF0C3961E, 6'd31, 3'b010); check("sll31", bus.c, 32'h00000000);
        step(1'b1, 32'h7A5B3C2D, 6'd8, 3'b000);  check("sra8_pos", bus.c, 32'h007A5B3C);

        // Overshift b = 40
`ifdef BARRELSHIFTER32_OVERSHIFT_EN
        step(1'b1, 32'hF0C3961E, 6'd40, 3'b000); check("ovs_sra", bus.c, 32'hFFFFFFFF);
        step(1'b1, 32'hF0C3961E, 6'd40, 3'b001); check("ovs_srl", bus.c, 32'h00000000);
        step(1'b1, 32'hF0C3961E, 6'd40, 3'b010); check("ovs_sll", bus.c, 32'h00000000);
        step(1'b1, 32'h7A5B3C2D, 6'd40, 3'b000); check("ovs_sra_pos", bus.c, 32'h00000000);
`else
        step(1'b1, 32'hF0C3961E, 6'd40, 3'b000); check("ovs_sra", bus.c, 32'hFFF0C396);
        step(1'b1, 32'hF0C3961E, 6'd40, 3'b001); check("ovs_srl", bus.c, 32'h00F0C396);
        step(1'b1, 32'hF0C3961E, 6'd40, 3'b010); check("ovs_sll", bus.c, 32'hC3961E00);
`endif

        // Full sweep, back-to-back, aluc[2] included
        for (int k = 0; k < 2; k++) begin
            for (int op = 0; op < 8; op++) begin
                for (int sh = 0; sh < 32; sh++) begin
                    step(1'b1, ops[k], 6'(sh), 3'(op));
                    check($sformatf("sweep_a%0d_op%0d_b%0d", k, op, sh), bus.c,
                          ref_shift(ops[k], 6'(sh), 3'(op)));
                    check("sweep_vld", {31'b0, bus.out_valid}, 32'h1);
                end
            end
        end

        // Hold: drop in_valid, toggle operands
        step(1'b1, 32'hF0C3961E, 6'd4, 3'b001);
        held = 32'h0F0C3961;
        check("hold_setup", bus.c, held);
        step(1'b0, 32'hDEADBEEF, 6'd7, 3'b010);
        check("hold_vld", {31'b0, bus.out_valid}, 32'h0);
        check("hold_c", bus.c, held);
        bus.a = 32'h5555AAAA; bus.b = 6'd13; bus.aluc = 3'b000;
        #2;
        check("hold_between_edges", bus.c, held);
        step(1'b0, 32'h0000FFFF, 6'd3, 3'b001);
        check("hold_c2", bus.c, held);
        check("hold_vld2", {31'b0, bus.out_valid}, 32'h0);

        // Operands changed between edges only matter at the next edge
        step(1'b1, 32'h8000_0001, 6'd1, 3'b000);
        bus.a = 32'h0; bus.b = 6'd0;
        #2;
        check("between_edges", bus.c, 32'hC000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
